fft_frame_sched: RTL and testbench

Frame scheduler and arbiter in front of the 512-point FFT pipeline. It shares the single FFT datapath between two sample sources, granting whole frames round-robin. For each granted frame it drives the pipeline's `valid` for exactly 32 consecutive beats (16 samples per beat) and selects the source for the input mux. It also tracks frames in flight, so downstream logic can tag each 32-beat output frame with its source channel and frame boundaries.

---
 rtl/fft_frame_sched_if.sv | 37 +++
 rtl/fft_frame_sched.sv | 186 ++++++++++++++++++
 tb/tb_fft_frame_sched.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_sched_if.sv
// Handshake and status bundle between the FFT frame scheduler and its environment.
// req is a level held by the source until its gnt pulse; gnt, fft_valid and all
// output-side signals are registered and sampled on the rising clk edge.
interface fft_frame_sched_if #(
  parameter int BEATS     = 32,
  parameter int TAG_DEPTH = 8
);
  localparam int BW = $clog2(BEATS);
  localparam int IW = $clog2(TAG_DEPTH) + 1;

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          fft_valid;
  logic          mux_sel;
  logic [BW-1:0] beat_idx;
  logic          out_valid;
  logic          out_ch;
  logic          out_sof;
  logic          out_eof;
  logic [IW-1:0] inflight;
  logic          busy;
  logic [1:0]    dbg_state;

  modport master (
    input  req,
    output gnt, fft_valid, mux_sel, beat_idx,
    output out_valid, out_ch, out_sof, out_eof,
    output inflight, busy, dbg_state
  );

  modport slave (
    output req,
    input  gnt, fft_valid, mux_sel, beat_idx,
    input  out_valid, out_ch, out_sof, out_eof,
    input  inflight, busy, dbg_state
  );
endinterface

// File: rtl/fft_frame_sched.sv
// Round-robin frame scheduler for a shared FFT pipeline: launches 32-beat frames
// from two sources and tags each launched frame so its output frame can be labelled.
module fft_frame_sched #(
  parameter int BEATS     = 32,
  parameter int FFT_LAT   = 180,
  parameter int TAG_DEPTH = 8,
  parameter int GAP       = 0
) (
  input  logic               clk,
  input  logic               rst,
  fft_frame_sched_if.master  bus
);
  localparam int BW = $clog2(BEATS);
  localparam int IW = $clog2(TAG_DEPTH) + 1;
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int GW = $clog2(GAP + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_gnt, w_gnt_nxt;
  logic          r_fft_valid, w_fft_valid_nxt;
  logic          r_mux_sel, w_mux_sel_nxt;
  logic [BW-1:0] r_beat_idx, w_beat_idx_nxt;
  logic [GW-1:0] r_gap_cnt, w_gap_cnt_nxt;
  logic          r_rr_ptr, w_rr_ptr_nxt;
  logic          w_try_grant, w_can_grant, w_win, w_push;

  logic [15:0]   r_ts;
  logic          r_tag_ch [TAG_DEPTH];
  logic [15:0]   r_tag_ts [TAG_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_cand_ptr;
  logic [IW-1:0] r_inflight;
  logic          w_pop, w_cand_ok, w_start;

  logic          r_out_valid, r_out_ch, r_out_sof, r_out_eof;
  logic [BW-1:0] r_out_beat;

  // Round robin between two channels: r_rr_ptr holds the channel with priority.
  assign w_can_grant = (|bus.req) && (r_inflight < IW'(TAG_DEPTH));
  assign w_win       = bus.req[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = 2'b00;
    w_fft_valid_nxt = 1'b0;
    w_mux_sel_nxt   = r_mux_sel;
    w_beat_idx_nxt  = '0;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_try_grant     = 1'b0;
    w_push          = 1'b0;

    case (r_state)
      S_IDLE: w_try_grant = 1'b1;
      S_BURST: begin
        if (r_beat_idx == BW'(BEATS - 1)) begin
          if (GAP > 0) begin
            w_state_nxt   = S_GAP;
            w_gap_cnt_nxt = '0;
          end else begin
            w_try_grant = 1'b1;
          end
        end else begin
          w_fft_valid_nxt = 1'b1;
          w_beat_idx_nxt  = r_beat_idx + BW'(1);
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GW'(GAP - 1)) w_try_grant = 1'b1;
        else                            w_gap_cnt_nxt = r_gap_cnt + GW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_try_grant) begin
      if (w_can_grant) begin
        w_state_nxt     = S_BURST;
        w_gnt_nxt       = w_win ? 2'b10 : 2'b01;
        w_fft_valid_nxt = 1'b1;
        w_beat_idx_nxt  = '0;
        w_mux_sel_nxt   = w_win;
        w_rr_ptr_nxt    = ~w_win;
        w_push          = 1'b1;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= 2'b00;
      r_fft_valid <= 1'b0;
      r_mux_sel   <= 1'b0;
      r_beat_idx  <= '0;
      r_gap_cnt   <= '0;
      r_rr_ptr    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_fft_valid <= w_fft_valid_nxt;
      r_mux_sel   <= w_mux_sel_nxt;
      r_beat_idx  <= w_beat_idx_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
    end
  end

  // The tag records the cycle of the frame's first beat, i.e. the next r_ts value.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_ch[r_wr_ptr] <= w_mux_sel_nxt;
      r_tag_ts[r_wr_ptr] <= r_ts + 16'd1;
    end
  end

  // On the last output beat the head is being popped, so the following tag is the
  // candidate; this lets back-to-back launches produce back-to-back output frames.
  assign w_pop      = r_out_valid && r_out_eof;
  assign w_cand_ptr = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
  assign w_cand_ok  = w_pop ? (r_inflight > IW'(1))
                            : (!r_out_valid && (r_inflight != '0));
  assign w_start    = w_cand_ok &&
                      ((r_ts - r_tag_ts[w_cand_ptr]) == 16'(FFT_LAT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts       <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= '0;
    end else begin
      r_ts <= r_ts + 16'd1;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_inflight <= r_inflight + IW'(1);
        2'b01:   r_inflight <= r_inflight - IW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_out_beat  <= '0;
    end else if (w_start) begin
      r_out_valid <= 1'b1;
      r_out_ch    <= r_tag_ch[w_cand_ptr];
      r_out_sof   <= 1'b1;
      r_out_eof   <= (BEATS == 1);
      r_out_beat  <= '0;
    end else if (r_out_valid && !r_out_eof) begin
      r_out_sof   <= 1'b0;
      r_out_eof   <= (r_out_beat == BW'(BEATS - 2));
      r_out_beat  <= r_out_beat + BW'(1);
    end else begin
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_out_beat  <= '0;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.fft_valid = r_fft_valid;
  assign bus.mux_sel   = r_mux_sel;
  assign bus.beat_idx  = r_beat_idx;
  assign bus.out_valid = r_out_valid;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_sof   = r_out_sof;
  assign bus.out_eof   = r_out_eof;
  assign bus.inflight  = r_inflight;
  assign bus.busy      = (r_inflight != '0) || (r_state != S_IDLE);
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched: default, GAP=3 and TAG_DEPTH=2 instances
// share clock and reset; output channels are scoreboarded against an expected queue.
module tb_fft_frame_sched;
  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  logic [0:0] exp_q[$];
  int         launch_q[$];
  int         obeat = 0;

  int         t_gnt_q[$];
  int         t_eof1 = -1;
  int         t_max = 0;

  fft_frame_sched_if #(.BEATS(32), .TAG_DEPTH(8)) ifa ();
  fft_frame_sched_if #(.BEATS(32), .TAG_DEPTH(8)) ifg ();
  fft_frame_sched_if #(.BEATS(32), .TAG_DEPTH(2)) ift ();

  fft_frame_sched #(.BEATS(32), .FFT_LAT(180), .TAG_DEPTH(8), .GAP(0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  fft_frame_sched #(.BEATS(32), .FFT_LAT(180), .TAG_DEPTH(8), .GAP(3))
    dut_g (.clk(clk), .rst(rst), .bus(ifg));
  fft_frame_sched #(.BEATS(32), .FFT_LAT(180), .TAG_DEPTH(2), .GAP(0))
    dut_t (.clk(clk), .rst(rst), .bus(ift));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    repeat (2) @(posedge clk);
    #1;
    launch_q.delete();
    rst = 1'b0;
    step();
  endtask

  task automatic drain_a(input string tag);
    for (int i = 0; i < 400 && (ifa.inflight != 0 || ifa.busy); i++) step();
    chk({tag, "_inflight"}, 32'(ifa.inflight), 0);
    chk({tag, "_busy"}, 32'(ifa.busy), 0);
  endtask

  // scoreboard / monitors
  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.gnt != 2'b00) launch_q.push_back(cyc);
      if (ifa.out_valid) begin
        if (ifa.out_sof) begin
          obeat = 0;
          chk("exp_q_nonempty", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) chk("out_ch", 32'(ifa.out_ch), 32'(exp_q.pop_front()));
          chk("launch_nonempty", 32'(launch_q.size() != 0), 1);
          if (launch_q.size() != 0) chk("out_latency", 32'(cyc - launch_q.pop_front()), 180);
        end else begin
          obeat++;
        end
        if (ifa.out_eof) chk("eof_beat", 32'(obeat), 31);
      end
      if (32'(ift.inflight) > 32'(t_max)) t_max = int'(ift.inflight);
      if (ift.gnt != 2'b00) t_gnt_q.push_back(cyc);
      if (ift.out_eof && t_eof1 < 0) t_eof1 = cyc;
    end
  end

  initial begin
    int fcnt, gcnt, bubbles, idle;
    rst = 1'b0;
    ifa.req = 2'b00;
    ifg.req = 2'b00;
    ift.req = 2'b00;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(ifa.gnt), 0);
    chk("rst_fft_valid", 32'(ifa.fft_valid), 0);
    chk("rst_mux_sel", 32'(ifa.mux_sel), 0);
    chk("rst_beat_idx", 32'(ifa.beat_idx), 0);
    chk("rst_out_valid", 32'(ifa.out_valid), 0);
    chk("rst_out_ch", 32'(ifa.out_ch), 0);
    chk("rst_out_sof", 32'(ifa.out_sof), 0);
    chk("rst_out_eof", 32'(ifa.out_eof), 0);
    chk("rst_inflight", 32'(ifa.inflight), 0);
    chk("rst_busy", 32'(ifa.busy), 0);
    rst = 1'b0;
    step();

    // single frame from channel 0
    ifa.req = 2'b01;
    exp_q.push_back(1'b0);
    step();
    chk("t1_gnt", 32'(ifa.gnt), 32'h1);
    chk("t1_fv0", 32'(ifa.fft_valid), 1);
    chk("t1_beat0", 32'(ifa.beat_idx), 0);
    chk("t1_mux", 32'(ifa.mux_sel), 0);
    ifa.req = 2'b00;
    for (int i = 1; i < 32; i++) begin
      step();
      chk("t1_beat", 32'(ifa.beat_idx), 32'(i));
      chk("t1_fv", 32'(ifa.fft_valid), 1);
    end
    step();
    chk("t1_fv_end", 32'(ifa.fft_valid), 0);
    drain_a("t1");

    // both channels continuously, back to back
    do_reset();
    ifa.req = 2'b11;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    bubbles = 0;
    for (int k = 0; k < 128; k++) begin
      step();
      if (k % 32 == 0) begin
        chk("t2_gnt", 32'(ifa.gnt), ((k / 32) % 2 == 0) ? 32'h1 : 32'h2);
        chk("t2_mux", 32'(ifa.mux_sel), 32'((k / 32) % 2));
      end
      if (k == 96) ifa.req = 2'b00;
      if (ifa.fft_valid !== 1'b1) bubbles++;
    end
    chk("t2_bubbles", 32'(bubbles), 0);
    step();
    chk("t2_fv_end", 32'(ifa.fft_valid), 0);
    drain_a("t2");

    // req dropped at beat 10
    do_reset();
    ifa.req = 2'b01;
    exp_q.push_back(1'b0);
    step();
    fcnt = 0;
    gcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) step();
      if (ifa.fft_valid) fcnt++;
      if (ifa.gnt != 2'b00) gcnt++;
      if (ifa.fft_valid && ifa.beat_idx == 5'd10) ifa.req = 2'b00;
    end
    chk("t5_beats", 32'(fcnt), 32);
    chk("t5_grants", 32'(gcnt), 1);
    drain_a("t5");

    // reset at beat 15 of the second frame
    do_reset();
    ifa.req = 2'b11;
    step();
    for (int k = 1; k <= 47; k++) step();
    chk("t6_pre_beat", 32'(ifa.beat_idx), 15);
    chk("t6_pre_mux", 32'(ifa.mux_sel), 1);
    rst = 1'b1;
    #1;
    chk("t6_gnt", 32'(ifa.gnt), 0);
    chk("t6_fv", 32'(ifa.fft_valid), 0);
    chk("t6_mux", 32'(ifa.mux_sel), 0);
    chk("t6_beat", 32'(ifa.beat_idx), 0);
    chk("t6_out_valid", 32'(ifa.out_valid), 0);
    chk("t6_inflight", 32'(ifa.inflight), 0);
    chk("t6_busy", 32'(ifa.busy), 0);
    repeat (2) @(posedge clk);
    #1;
    launch_q.delete();
    rst = 1'b0;
    step();
    chk("t6_regrant", 32'(ifa.gnt), 32'h1);
    ifa.req = 2'b00;
    exp_q.push_back(1'b0);
    drain_a("t6");

    // GAP=3 instance
    do_reset();
    ifg.req = 2'b01;
    step();
    chk("t3_gnt1", 32'(ifg.gnt), 32'h1);
    for (int i = 0; i < 40 && ifg.fft_valid; i++) step();
    idle = 0;
    for (int i = 0; i < 10 && !ifg.fft_valid; i++) begin
      idle++;
      step();
    end
    chk("t3_idle", 32'(idle), 3);
    chk("t3_gnt2", 32'(ifg.gnt), 32'h1);
    ifg.req = 2'b00;

    // TAG_DEPTH=2 instance
    do_reset();
    ift.req = 2'b01;
    for (int i = 0; i < 400 && t_gnt_q.size() < 3; i++) step();
    ift.req = 2'b00;
    chk("t4_grants", 32'(t_gnt_q.size()), 3);
    chk("t4_b2b", 32'(t_gnt_q[1] - t_gnt_q[0]), 32);
    chk("t4_gnt3_after_pop", 32'(t_gnt_q[2] > t_eof1 && t_eof1 >= 0), 1);
    chk("t4_gnt3_prompt", 32'(t_gnt_q[2] <= t_eof1 + 2), 1);
    for (int i = 0; i < 600 && ift.inflight != 0; i++) step();
    chk("t4_inflight_end", 32'(ift.inflight), 0);
    chk("t4_inflight_max", 32'(t_max), 2);

    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
